// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU instruction controller.
// Optional build macro: ALU_CTRL_ZERO_REG_EN (r0 read-only).
package alu_ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_CMPI  = 4'hB;
   localparam logic [3:0] EXT_NOP  = 4'h0;
   localparam logic [3:0] EXT_CMP  = 4'hB;

   localparam int INSTR_W = 16;
   localparam int OP_LO   = 12;
   localparam int RD_LO   = 8;
   localparam int EXT_LO  = 4;
   localparam int RS_LO   = 0;
   localparam int IMM_HI  = 7;
endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode: register selects, ALU opcode, immediate and writeback qualifier.
// Honours ALU_CTRL_ZERO_REG_EN (no writeback to r0 when defined).
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int SELW = 4
) (
   input  logic [INSTR_W-1:0] i_instr,
   output logic [SELW-1:0]    o_rdest,
   output logic [SELW-1:0]    o_rsrc,
   output logic [7:0]         o_alu_op,
   output logic               o_imm_sel,
   output logic [15:0]        o_imm_out,
   output logic               o_wb_en
);
   logic [3:0] w_op;
   logic [3:0] w_ext;

   assign w_op  = i_instr[OP_LO +: 4];
   assign w_ext = i_instr[EXT_LO +: 4];

   always_comb begin
      o_rdest   = i_instr[RD_LO +: SELW];
      o_rsrc    = i_instr[RS_LO +: SELW];
      o_alu_op  = {w_op, 4'h0};
      o_imm_sel = 1'b1;
      o_imm_out = {{8{i_instr[IMM_HI]}}, i_instr[IMM_HI:0]};
      if (w_op == OP_RTYPE) begin
         o_alu_op  = {4'h0, w_ext};
         o_imm_sel = 1'b0;
         o_imm_out = '0;
      end
      // Compares and NOP retire without touching the register file.
      o_wb_en = !(((w_op == OP_RTYPE) && ((w_ext == EXT_NOP) || (w_ext == EXT_CMP)))
                  || (w_op == OP_CMPI));
`ifdef ALU_CTRL_ZERO_REG_EN
      if (o_rdest == '0) o_wb_en = 1'b0;
`endif
   end
endmodule

// File: rtl/alu_ctrl_fsm.sv
// Four-state instruction sequencer (IDLE/DECODE/EXECUTE/WRITEBACK) driving the ALU datapath controls.
// Optional build macro: ALU_CTRL_ZERO_REG_EN (r0 read-only).
module alu_ctrl_fsm
   import alu_ctrl_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int SELW  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [SELW-1:0]  src_sel,
   output logic [SELW-1:0]  dst_sel,
   output logic             imm_sel,
   output logic [15:0]      imm_out,
   output logic [7:0]       alu_op,
   output logic             buff_en,
   output logic [NREGS-1:0] reg_en,
   output logic             done
);
   localparam logic [NREGS-1:0] ONE = NREGS'(1);

   state_t           r_state;
   logic [SELW-1:0]  r_src_sel, r_dst_sel;
   logic             r_imm_sel, r_buff_en, r_done, r_wb_en;
   logic [15:0]      r_imm_out;
   logic [7:0]       r_alu_op;
   logic [NREGS-1:0] r_reg_en;

   logic [SELW-1:0]  w_rdest, w_rsrc;
   logic [7:0]       w_alu_op;
   logic             w_imm_sel, w_wb_en;
   logic [15:0]      w_imm_out;

   alu_ctrl_decode #(.SELW(SELW)) u_decode (
      .i_instr   (instr),
      .o_rdest   (w_rdest),
      .o_rsrc    (w_rsrc),
      .o_alu_op  (w_alu_op),
      .o_imm_sel (w_imm_sel),
      .o_imm_out (w_imm_out),
      .o_wb_en   (w_wb_en)
   );

   // Gated with reset so ready is low for the whole reset window, high the instant it releases.
   assign instr_ready = (r_state == S_IDLE) && reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_src_sel <= '0;
         r_dst_sel <= '0;
         r_imm_sel <= 1'b0;
         r_imm_out <= '0;
         r_alu_op  <= '0;
         r_wb_en   <= 1'b0;
         r_buff_en <= 1'b0;
         r_reg_en  <= '0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (instr_valid) begin
               r_state   <= S_DECODE;
               r_src_sel <= w_rdest;
               r_dst_sel <= w_rsrc;
               r_imm_sel <= w_imm_sel;
               r_imm_out <= w_imm_out;
               r_alu_op  <= w_alu_op;
               r_wb_en   <= w_wb_en;
            end
            S_DECODE: begin
               r_state   <= S_EXEC;
               r_buff_en <= 1'b1;
            end
            S_EXEC: begin
               r_state  <= S_WB;
               r_reg_en <= r_wb_en ? (ONE << r_src_sel) : '0;
               r_done   <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               r_src_sel <= '0;
               r_dst_sel <= '0;
               r_imm_sel <= 1'b0;
               r_imm_out <= '0;
               r_alu_op  <= '0;
               r_wb_en   <= 1'b0;
               r_buff_en <= 1'b0;
               r_reg_en  <= '0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign src_sel = r_src_sel;
   assign dst_sel = r_dst_sel;
   assign imm_sel = r_imm_sel;
   assign imm_out = r_imm_out;
   assign alu_op  = r_alu_op;
   assign buff_en = r_buff_en;
   assign reg_en  = r_reg_en;
   assign done    = r_done;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed scenarios plus random words against a field-level model.
module tb_alu_ctrl_fsm;
   logic        clk = 1'b0, reset = 1'b0, instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready, imm_sel, buff_en, done;
   logic [3:0]  src_sel, dst_sel;
   logic [15:0] imm_out, reg_en;
   logic [7:0]  alu_op;
   int errors = 0, checks = 0;

   typedef struct packed {
      logic rdy; logic [3:0] src; logic [3:0] dst; logic isel; logic [15:0] imm;
      logic [7:0] op; logic buff; logic [15:0] ren; logic dn;
   } obs_t;
   obs_t obs [5];

   alu_ctrl_fsm dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .src_sel(src_sel), .dst_sel(dst_sel),
      .imm_sel(imm_sel), .imm_out(imm_out), .alu_op(alu_op),
      .buff_en(buff_en), .reg_en(reg_en), .done(done)
   );

   always #5 clk = ~clk;

   function automatic obs_t snap();
      obs_t s;
      s.rdy = instr_ready; s.src = src_sel; s.dst = dst_sel; s.isel = imm_sel;
      s.imm = imm_out; s.op = alu_op; s.buff = buff_en; s.ren = reg_en; s.dn = done;
      return s;
   endfunction

   // Reference model: fields by plain arithmetic on the instruction word.
   function automatic int f_op(input logic [15:0] w);  return int'(w) / 4096;       endfunction
   function automatic int f_rd(input logic [15:0] w);  return (int'(w) / 256) % 16; endfunction
   function automatic int f_ext(input logic [15:0] w); return (int'(w) / 16) % 16;  endfunction
   function automatic int f_rs(input logic [15:0] w);  return int'(w) % 16;         endfunction

   function automatic logic [7:0] m_alu(input logic [15:0] w);
      return (f_op(w) == 0) ? 8'(f_ext(w)) : 8'(f_op(w) * 16);
   endfunction
   function automatic logic [15:0] m_imm(input logic [15:0] w);
      int lo = int'(w) % 256;
      if (f_op(w) == 0) return 16'd0;
      return (lo >= 128) ? 16'(lo + 65280) : 16'(lo);
   endfunction
   function automatic logic [15:0] m_wb(input logic [15:0] w);
      bit wb = !(f_op(w) == 11 || (f_op(w) == 0 && (f_ext(w) == 0 || f_ext(w) == 11)));
`ifdef ALU_CTRL_ZERO_REG_EN
      if (f_rd(w) == 0) wb = 0;
`endif
      return wb ? 16'(1 << f_rd(w)) : 16'd0;
   endfunction
   function automatic obs_t m_cycle(input logic [15:0] w, input int k);
      obs_t e = '0;
      if (k == 0 || k == 4) begin e.rdy = 1'b1; return e; end
      e.src = 4'(f_rd(w)); e.dst = 4'(f_rs(w)); e.isel = (f_op(w) != 0);
      e.imm = m_imm(w); e.op = m_alu(w); e.buff = (k >= 2);
      e.ren = (k == 3) ? m_wb(w) : 16'd0; e.dn = (k == 3);
      return e;
   endfunction

   // Offer one word from IDLE and record outputs: obs[0] pre-accept, obs[1..4] the following cycles.
   task automatic issue(input logic [15:0] w);
      @(posedge clk); #1;
      instr = w; instr_valid = 1'b1;
      @(negedge clk); obs[0] = snap();
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = 16'($urandom);
      for (int k = 1; k <= 4; k++) begin @(negedge clk); obs[k] = snap(); end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({instr_ready, snap()} !== '0) begin errors++;
         $display("FAIL reset_outputs: got %h want 0", snap()); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1 checks++;
      if (instr_ready !== 1'b1) begin errors++;
         $display("FAIL reset_release_ready: got %b want 1", instr_ready); end
   endtask

   task automatic test_rtype();
      issue(16'h0352);
      checks++;
      if (obs[1].op !== 8'h05 || obs[1].src !== 4'd3 || obs[1].dst !== 4'd2 || obs[1].isel !== 1'b0) begin
         errors++; $display("FAIL rtype_decode: got op=%h src=%0d dst=%0d isel=%b want 05 3 2 0",
                            obs[1].op, obs[1].src, obs[1].dst, obs[1].isel); end
      checks++;
      if (obs[3].ren !== 16'h0008 || obs[3].dn !== 1'b1) begin errors++;
         $display("FAIL rtype_wb: got reg_en=%h done=%b want 0008 1", obs[3].ren, obs[3].dn); end
      checks++;
      if (obs[2].ren !== 16'h0 || obs[2].dn !== 1'b0 || obs[4].ren !== 16'h0 || obs[4].dn !== 1'b0) begin
         errors++; $display("FAIL rtype_wb_window: got c2=%h/%b c4=%h/%b want zero",
                            obs[2].ren, obs[2].dn, obs[4].ren, obs[4].dn); end
      checks++;
      if (obs[1].rdy !== 1'b0 || obs[4].rdy !== 1'b1) begin errors++;
         $display("FAIL rtype_ready: got c1=%b c4=%b want 0 1", obs[1].rdy, obs[4].rdy); end
   endtask

   task automatic test_itype();
      issue(16'h51F6);
      checks++;
      if (obs[1].imm !== 16'hFFF6 || obs[1].isel !== 1'b1 || obs[1].op !== 8'h50) begin errors++;
         $display("FAIL itype_decode: got imm=%h isel=%b op=%h want FFF6 1 50",
                  obs[1].imm, obs[1].isel, obs[1].op); end
      checks++;
      if (obs[3].ren !== 16'h0002 || obs[3].imm !== 16'hFFF6 || obs[3].src !== 4'd1) begin errors++;
         $display("FAIL itype_wb: got reg_en=%h imm=%h src=%0d want 0002 FFF6 1",
                  obs[3].ren, obs[3].imm, obs[3].src); end
   endtask

   task automatic test_nowb();
      logic [15:0] words [3] = '{16'h04B7, 16'h0000, 16'hB312};
      logic [15:0] acc;
      foreach (words[i]) begin
         issue(words[i]);
         acc = obs[0].ren | obs[1].ren | obs[2].ren | obs[3].ren | obs[4].ren;
         checks++;
         if (acc !== 16'h0 || {obs[1].dn, obs[2].dn, obs[3].dn, obs[4].dn} !== 4'b0010) begin errors++;
            $display("FAIL nowb_%h: got reg_en_or=%h done=%b%b%b%b want 0000 0010", words[i], acc,
                     obs[1].dn, obs[2].dn, obs[3].dn, obs[4].dn); end
      end
      issue(16'h0052);
      checks++;
`ifdef ALU_CTRL_ZERO_REG_EN
      if (obs[3].ren !== 16'h0000 || obs[3].dn !== 1'b1) begin errors++;
         $display("FAIL r0_write: got reg_en=%h done=%b want 0000 1", obs[3].ren, obs[3].dn); end
`else
      if (obs[3].ren !== 16'h0001 || obs[3].dn !== 1'b1) begin errors++;
         $display("FAIL r0_write: got reg_en=%h done=%b want 0001 1", obs[3].ren, obs[3].dn); end
`endif
   endtask

   task automatic test_random();
      logic [15:0] w;
      obs_t e;
      for (int n = 0; n < 24; n++) begin
         w = 16'($urandom);
         if (n % 4 == 0) w[15:12] = 4'h0;
         issue(w);
         for (int k = 0; k <= 4; k++) begin
            e = m_cycle(w, k);
            checks++;
            if (obs[k] !== e) begin errors++;
               $display("FAIL random_%h_c%0d: got %h want %h", w, k, obs[k], e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] held;
      int dones = 0;
      held = '0;
      @(posedge clk); #1 instr_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         instr = 16'($urandom);
         @(negedge clk);
         checks++;
         if (instr_ready !== (c % 4 == 0)) begin errors++;
            $display("FAIL b2b_ready_c%0d: got %b want %b", c, instr_ready, (c % 4 == 0)); end
         if (c % 4 == 0) held = instr;
         if (c % 4 == 1) begin
            checks++;
            if (src_sel !== 4'(f_rd(held)) || dst_sel !== 4'(f_rs(held)) || alu_op !== m_alu(held)) begin
               errors++; $display("FAIL b2b_latch_c%0d: got %h/%h/%h want %h/%h/%h", c, src_sel, dst_sel,
                                  alu_op, 4'(f_rd(held)), 4'(f_rs(held)), m_alu(held)); end
         end
         if (done === 1'b1) dones++;
      end
      instr_valid = 1'b0;
      checks++;
      if (dones != 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      logic [15:0] ren_or = '0;
      @(posedge clk); #1 instr = 16'h0352; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (buff_en !== 1'b1) begin errors++; $display("FAIL midrst_exec: got buff_en=%b want 1", buff_en); end
      #2 reset = 1'b0;
      #1 checks++;
      if ({instr_ready, snap()} !== '0) begin errors++;
         $display("FAIL midrst_async: got %h want 0", snap()); end
      @(posedge clk); #1;
      checks++;
      if ({instr_ready, snap()} !== '0) begin errors++;
         $display("FAIL midrst_hold: got %h want 0", snap()); end
      reset = 1'b1;
      #1 checks++;
      if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", instr_ready); end
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
         ren_or = ren_or | reg_en;
      end
      checks++;
      if (dones != 0 || ren_or !== 16'h0) begin errors++;
         $display("FAIL midrst_lost: got done_count=%0d reg_en_or=%h want 0 0000", dones, ren_or); end
      issue(16'h0352);
      checks++;
      if (obs[3].ren !== 16'h0008 || obs[3].dn !== 1'b1) begin errors++;
         $display("FAIL midrst_recover: got reg_en=%h done=%b want 0008 1", obs[3].ren, obs[3].dn); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_nowb();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
